// File: rtl/slope_adc_ctrl_if.sv
// Handshake and data bundle between the slope-ADC controller and its user/analog front end.
interface slope_adc_ctrl_if #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned NCH   = 4
);
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic             start;
    logic             cont_en;
    logic             comp;
    logic             cap_rst;
    logic [CHW-1:0]   ch_sel;
    logic [WIDTH-1:0] data;
    logic [CHW-1:0]   data_ch;
    logic             data_valid;
    logic             ovf;
    logic             busy;
    logic             sweep_done;

    // Environment side: issues requests, supplies the comparator, consumes results.
    modport master (
        output start, cont_en, comp,
        input  cap_rst, ch_sel, data, data_ch, data_valid, ovf, busy, sweep_done
    );

    // Controller side.
    modport slave (
        input  start, cont_en, comp,
        output cap_rst, ch_sel, data, data_ch, data_valid, ovf, busy, sweep_done
    );
endinterface

// File: rtl/slope_adc_ctrl.sv
// Single-slope ADC sequencer: discharges the ramp capacitor, counts until the
// comparator trips (or the counter saturates), then holds and steps the mux.
module slope_adc_ctrl #(
    parameter int unsigned WIDTH   = 9,
    parameter int unsigned NCH     = 4,
    parameter int unsigned T_DISCH = 16,
    parameter int unsigned T_HOLD  = 11
) (
    input  logic              clk,
    input  logic              rst,
    slope_adc_ctrl_if.slave   bus
);
    localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned TMAX = (T_DISCH > T_HOLD) ? T_DISCH : T_HOLD;
    localparam int unsigned DW   = $clog2(TMAX + 1);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [CHW-1:0]   CH_LAST  = CHW'(NCH - 1);
    localparam logic [DW-1:0]    DISCH_LAST = DW'(T_DISCH - 1);
    localparam logic [DW-1:0]    HOLD_LAST  = DW'(T_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DISCH = 2'd1,
        S_COUNT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t           state_q;
    logic             comp_meta_q;
    logic             comp_s_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [DW-1:0]    dly_q;
    logic [DW-1:0]    dly_d;
    logic             cap_rst_q;
    logic [CHW-1:0]   ch_sel_q;
    logic [WIDTH-1:0] data_q;
    logic [CHW-1:0]   data_ch_q;
    logic             data_valid_q;
    logic             ovf_q;
    logic             busy_q;
    logic             sweep_done_q;

    assign cnt_d = cnt_q + WIDTH'(1);
    assign dly_d = dly_q + DW'(1);

    // Two-flop synchroniser for the asynchronous comparator output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp_meta_q <= 1'b0;
            comp_s_q    <= 1'b0;
        end else begin
            comp_meta_q <= bus.comp;
            comp_s_q    <= comp_meta_q;
        end
    end

    // Conversion sequencer with registered outputs; strobes default low each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            dly_q        <= '0;
            cap_rst_q    <= 1'b1;
            ch_sel_q     <= '0;
            data_q       <= '0;
            data_ch_q    <= '0;
            data_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            sweep_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cap_rst_q <= 1'b1;
                    busy_q    <= 1'b0;
                    if (bus.start || bus.cont_en) begin
                        state_q  <= S_DISCH;
                        ch_sel_q <= '0;
                        dly_q    <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                S_DISCH: begin
                    cap_rst_q <= 1'b1;
                    busy_q    <= 1'b1;
                    if (dly_q == DISCH_LAST) begin
                        state_q   <= S_COUNT;
                        cnt_q     <= '0;
                        dly_q     <= '0;
                        cap_rst_q <= 1'b0;
                    end else begin
                        dly_q <= dly_d;
                    end
                end
                S_COUNT: begin
                    // Comparator trip takes priority over saturation on the same cycle.
                    if (comp_s_q) begin
                        data_q       <= cnt_q;
                        ovf_q        <= 1'b0;
                        data_ch_q    <= ch_sel_q;
                        data_valid_q <= 1'b1;
                        cap_rst_q    <= 1'b1;
                        dly_q        <= '0;
                        state_q      <= S_HOLD;
                    end else if (cnt_q == CNT_MAX) begin
                        data_q       <= CNT_MAX;
                        ovf_q        <= 1'b1;
                        data_ch_q    <= ch_sel_q;
                        data_valid_q <= 1'b1;
                        cap_rst_q    <= 1'b1;
                        dly_q        <= '0;
                        state_q      <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_HOLD: begin
                    cap_rst_q <= 1'b1;
                    if (dly_q == HOLD_LAST) begin
                        dly_q <= '0;
                        if (ch_sel_q != CH_LAST) begin
                            ch_sel_q <= ch_sel_q + CHW'(1);
                            state_q  <= S_DISCH;
                        end else begin
                            sweep_done_q <= 1'b1;
                            ch_sel_q     <= '0;
                            if (bus.cont_en) begin
                                state_q <= S_DISCH;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end else begin
                        dly_q <= dly_d;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    cap_rst_q <= 1'b1;
                    busy_q    <= 1'b0;
                    dly_q     <= '0;
                    cnt_q     <= '0;
                end
            endcase
        end
    end

    assign bus.cap_rst    = cap_rst_q;
    assign bus.ch_sel     = ch_sel_q;
    assign bus.data       = data_q;
    assign bus.data_ch    = data_ch_q;
    assign bus.data_valid = data_valid_q;
    assign bus.ovf        = ovf_q;
    assign bus.busy       = busy_q;
    assign bus.sweep_done = sweep_done_q;
endmodule

// File: tb/tb_slope_adc_ctrl.sv
// Bench for slope_adc_ctrl: a ramp/comparator plant model drives comp, a
// scoreboard checks every result strobe against arithmetic expectations.
module tb_slope_adc_ctrl;
    localparam int unsigned WIDTH   = 9;
    localparam int unsigned NCH     = 4;
    localparam int unsigned T_DISCH = 16;
    localparam int unsigned T_HOLD  = 11;
    localparam int          MAXV    = (1 << WIDTH) - 1;
    localparam int          BUDGET  = 3000;

    typedef struct {
        int data;
        int ch;
        int ovf;
    } res_t;

    typedef struct {
        int thr;
        int exp_data;
        int exp_ovf;
    } vec_t;

    logic clk;
    logic rst;

    slope_adc_ctrl_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

    slope_adc_ctrl #(
        .WIDTH   (WIDTH),
        .NCH     (NCH),
        .T_DISCH (T_DISCH),
        .T_HOLD  (T_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total;
    int   bad;
    int   sd_cnt;
    int   run;
    int   idle_seen;
    bit   first;
    bit   prev_dv;
    bit   prev_sd;
    int   ramp;
    int   thr_arr [NCH];
    res_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected result of one conversion for a comparator that trips once the
    // ramp has run thr cycles: two synchroniser cycles of latency on top.
    function automatic res_t model(input int thr, input int ch);
        res_t r;
        r.ch = ch;
        if (thr == 0) begin
            r.data = 0;
            r.ovf  = 0;
        end else if (thr + 1 > MAXV) begin
            r.data = MAXV;
            r.ovf  = 1;
        end else begin
            r.data = thr + 1;
            r.ovf  = 0;
        end
        return r;
    endfunction

    // One clock: sample at the falling edge, score strobes, then update the plant.
    task automatic tick();
        res_t e;
        @(negedge clk);
        if (bus.data_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(bus.data_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("data", 32'(bus.data), 32'(e.data));
                check("data_ch", 32'(bus.data_ch), 32'(e.ch));
                check("ovf", 32'(bus.ovf), 32'(e.ovf));
            end
            check("valid_width", 32'(prev_dv), 32'd0);
        end
        if (bus.sweep_done) begin
            sd_cnt++;
            check("sweep_done_width", 32'(prev_sd), 32'd0);
        end
        if (!bus.busy) begin
            run       = 0;
            first     = 1'b1;
            idle_seen++;
        end else if (bus.cap_rst) begin
            run++;
        end else begin
            if (run != 0) begin
                check("cap_rst_run", 32'(run), first ? 32'(T_DISCH) : 32'(T_HOLD + T_DISCH));
                first = 1'b0;
            end
            run = 0;
        end
        prev_dv = bus.data_valid;
        prev_sd = bus.sweep_done;
        if (bus.cap_rst) ramp = 0;
        else             ramp++;
        bus.comp = (ramp >= thr_arr[bus.ch_sel]);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_sweeps(input int target);
        int n;
        n = 0;
        while (sd_cnt < target && n < BUDGET) begin
            tick();
            n++;
        end
        check("sweep_timeout", 32'(sd_cnt >= target), 32'd1);
    endtask

    task automatic set_thr(input int t);
        for (int c = 0; c < NCH; c++) thr_arr[c] = t;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_cap_rst"}, 32'(bus.cap_rst), 32'd1);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    vec_t vecs [8];

    initial begin
        int sd0;
        int idle0;
        int n;

        vecs[0] = '{thr: 36,   exp_data: 37,  exp_ovf: 0};
        vecs[1] = '{thr: 1000, exp_data: 511, exp_ovf: 1};
        vecs[2] = '{thr: 100,  exp_data: 101, exp_ovf: 0};
        vecs[3] = '{thr: 0,    exp_data: 0,   exp_ovf: 0};
        vecs[4] = '{thr: 511,  exp_data: 511, exp_ovf: 1};
        vecs[5] = '{thr: 510,  exp_data: 511, exp_ovf: 0};
        vecs[6] = '{thr: 1,    exp_data: 2,   exp_ovf: 0};
        vecs[7] = '{thr: 254,  exp_data: 255, exp_ovf: 0};

        total = 0; bad = 0; sd_cnt = 0; run = 0; idle_seen = 0;
        first = 1'b1; prev_dv = 1'b0; prev_sd = 1'b0; ramp = 0;
        set_thr(1000);
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.cont_en = 1'b0;
        bus.comp    = 1'b0;

        // Reset state.
        ticks(3);
        check("rst_cap_rst", 32'(bus.cap_rst), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_data", 32'(bus.data), 32'd0);
        check("rst_ch_sel", 32'(bus.ch_sel), 32'd0);
        check("rst_valid", 32'(bus.data_valid), 32'd0);
        rst = 1'b0;
        ticks(5);
        check_idle("post_rst");

        // Single sweeps over a table of comparator thresholds.
        for (int v = 0; v < 8; v++) begin
            set_thr(vecs[v].thr);
            for (int c = 0; c < NCH; c++)
                exp_q.push_back('{data: vecs[v].exp_data, ch: c, ovf: vecs[v].exp_ovf});
            sd0 = sd_cnt;
            pulse_start();
            wait_sweeps(sd0 + 1);
            ticks(20);
            check_idle("vec");
            check("vec_hold_data", 32'(bus.data), 32'(vecs[v].exp_data));
            check("vec_hold_ovf", 32'(bus.ovf), 32'(vecs[v].exp_ovf));
            check("vec_hold_ch", 32'(bus.data_ch), 32'(NCH - 1));
            check("vec_sweeps", 32'(sd_cnt), 32'(sd0 + 1));
        end

        // Continuous mode: back-to-back sweeps, then drop cont_en mid-sweep.
        set_thr(20);
        for (int s = 0; s < 3; s++)
            for (int c = 0; c < NCH; c++) exp_q.push_back(model(20, c));
        sd0 = sd_cnt;
        bus.cont_en = 1'b1;
        tick();
        wait_sweeps(sd0 + 1);
        idle0 = idle_seen;
        check("cont_wrap_ch", 32'(bus.ch_sel), 32'd0);
        check("cont_wrap_busy", 32'(bus.busy), 32'd1);
        wait_sweeps(sd0 + 2);
        check("cont_wrap2_busy", 32'(bus.busy), 32'd1);
        ticks(100);
        bus.cont_en = 1'b0;
        wait_sweeps(sd0 + 3);
        check("cont_end_busy", 32'(bus.busy), 32'd0);
        check("cont_no_idle", 32'(idle_seen - idle0), 32'd1);
        ticks(50);
        check_idle("cont_end");
        check("cont_sweeps", 32'(sd_cnt), 32'(sd0 + 3));

        // Reset in the middle of channel 1's count phase.
        set_thr(300);
        exp_q.push_back(model(300, 0));
        sd0 = sd_cnt;
        pulse_start();
        n = 0;
        while (exp_q.size() != 0 && n < BUDGET) begin tick(); n++; end
        check("rst_seq_ch0_done", 32'(exp_q.size()), 32'd0);
        n = 0;
        while (bus.cap_rst && n < 100) begin tick(); n++; end
        check("rst_seq_in_count", 32'(bus.cap_rst), 32'd0);
        ticks(50);
        #1 rst = 1'b1;
        #1;
        check("arst_cap_rst", 32'(bus.cap_rst), 32'd1);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_data", 32'(bus.data), 32'd0);
        check("arst_data_ch", 32'(bus.data_ch), 32'd0);
        check("arst_ovf", 32'(bus.ovf), 32'd0);
        check("arst_ch_sel", 32'(bus.ch_sel), 32'd0);
        check("arst_valid", 32'(bus.data_valid), 32'd0);
        check("arst_sweep_done", 32'(bus.sweep_done), 32'd0);
        ticks(3);
        rst = 1'b0;
        ticks(700);
        check_idle("rst_seq");
        check("rst_seq_sweeps", 32'(sd_cnt), 32'(sd0));

        // start while busy must not disturb the sweep.
        set_thr(40);
        for (int c = 0; c < NCH; c++) exp_q.push_back(model(40, c));
        sd0 = sd_cnt;
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            ticks(30);
            pulse_start();
        end
        wait_sweeps(sd0 + 1);
        ticks(100);
        check_idle("busy_start");
        check("busy_start_sweeps", 32'(sd_cnt), 32'(sd0 + 1));

        // Randomised per-channel thresholds against the arithmetic model.
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < NCH; c++) begin
                thr_arr[c] = int'($urandom_range(0, 530));
                exp_q.push_back(model(thr_arr[c], c));
            end
            sd0 = sd_cnt;
            pulse_start();
            wait_sweeps(sd0 + 1);
            ticks(5);
            check_idle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
